// File: rtl/multicycle_main_controller_pkg.sv
// Shared definitions for the multicycle CPU main controller: opcodes, state
// encodings, datapath mux encodings and the strobe bundle.
package multicycle_main_controller_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned FUNC_W  = 9;

  localparam logic [OP_W-1:0] OP_LOAD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_STORE  = 4'b0001;
  localparam logic [OP_W-1:0] OP_JUMP   = 4'b0010;
  localparam logic [OP_W-1:0] OP_BRANCH = 4'b0100;
  localparam logic [OP_W-1:0] OP_TYPEC  = 4'b1000;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_LOAD_MEM  = 4'd2,
    S_LOAD_WB   = 4'd3,
    S_STORE_MEM = 4'd4,
    S_JUMP      = 4'd5,
    S_BRANCH    = 4'd6,
    S_C_EXEC    = 4'd7,
    S_C_WB      = 4'd8,
    S_D_EXEC    = 4'd9,
    S_D_WB      = 4'd10,
    S_ERROR     = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       force_add;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  // Type-C functions are one-hot within the low eight bits only.
  function automatic logic func_valid(input logic [FUNC_W-1:0] func);
    logic [7:0] f;
    f = func[7:0];
    return !func[8] && (f != 8'd0) && ((f & (f - 8'd1)) == 8'd0);
  endfunction

  function automatic state_e decode_op(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] func);
    state_e nxt;
    if (op[3:2] == 2'b11) begin
      nxt = S_D_EXEC;
    end else begin
      case (op)
        OP_LOAD:   nxt = S_LOAD_MEM;
        OP_STORE:  nxt = S_STORE_MEM;
        OP_JUMP:   nxt = S_JUMP;
        OP_BRANCH: nxt = S_BRANCH;
        OP_TYPEC:  nxt = func_valid(func) ? S_C_EXEC : S_ERROR;
        default:   nxt = S_ERROR;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multicycle 16-bit CPU: sequences each instruction
// through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         Op,
  input  logic [8:0]         Func,
  input  logic               isNop,
  input  logic               isMoveTo,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ForceAdd,
  output logic [1:0]         PCSrc,
  output logic               Halted,
  output logic [COUNT_W-1:0] InstrCount
);

  state_e             state_q;
  state_e             state_d;
  logic               retire_c;
  ctrl_t              ctrl_c;
  ctrl_t              ctrl_gated;
  logic [COUNT_W-1:0] instr_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    retire_c = 1'b0;
    case (state_q)
      S_FETCH:     if (MemReady) state_d = S_DECODE;
      S_DECODE:    state_d = decode_op(Op, Func);
      S_LOAD_MEM:  if (MemReady) state_d = S_LOAD_WB;
      S_STORE_MEM: if (MemReady) state_d = S_FETCH;
      S_C_EXEC:    state_d = S_C_WB;
      S_D_EXEC:    state_d = S_D_WB;
      S_LOAD_WB, S_JUMP, S_BRANCH, S_C_WB, S_D_WB: state_d = S_FETCH;
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_ERROR;
    endcase
    // Every return to FETCH from elsewhere retires one instruction.
    retire_c = (state_d == S_FETCH) && (state_q != S_FETCH);
  end

  always_comb begin
    ctrl_c = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read = 1'b1;
        if (MemReady) begin
          ctrl_c.ir_write  = 1'b1;
          ctrl_c.pc_write  = 1'b1;
          ctrl_c.alu_src_b = SRCB_ONE;
          ctrl_c.force_add = 1'b1;
          ctrl_c.pc_src    = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = SRCB_SEXT;
        ctrl_c.force_add = 1'b1;
      end
      S_LOAD_MEM: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
      end
      S_LOAD_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      S_STORE_MEM: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
      end
      S_JUMP: begin
        ctrl_c.pc_write = 1'b1;
        ctrl_c.pc_src   = PCSRC_JUMP;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.pc_write  = Zero;
        ctrl_c.pc_src    = PCSRC_ALUOUT;
      end
      S_C_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
      end
      S_C_WB: begin
        ctrl_c.reg_write = !isNop;
        ctrl_c.reg_dst   = isMoveTo;
      end
      S_D_EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_ZEXT;
      end
      S_D_WB:  ctrl_c.reg_write = 1'b1;
      S_ERROR: ctrl_c.halted    = 1'b1;
      default: ctrl_c = '0;
    endcase
  end

  // Strobes follow rst_n directly so an aborted access drops immediately.
  assign ctrl_gated = rst_n ? ctrl_c : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        instr_count_q <= '0;
    else if (retire_c) instr_count_q <= instr_count_q + COUNT_W'(1);
  end

  assign PCWrite    = ctrl_gated.pc_write;
  assign IorD       = ctrl_gated.iord;
  assign MemRead    = ctrl_gated.mem_read;
  assign MemWrite   = ctrl_gated.mem_write;
  assign IRWrite    = ctrl_gated.ir_write;
  assign RegWrite   = ctrl_gated.reg_write;
  assign RegDst     = ctrl_gated.reg_dst;
  assign MemToReg   = ctrl_gated.mem_to_reg;
  assign ALUSrcA    = ctrl_gated.alu_src_a;
  assign ALUSrcB    = ctrl_gated.alu_src_b;
  assign ForceAdd   = ctrl_gated.force_add;
  assign PCSrc      = ctrl_gated.pc_src;
  assign Halted     = ctrl_gated.halted;
  assign InstrCount = instr_count_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Randomized self-checking bench for multicycle_main_controller; a 4-bit
// counter instance shares the stimulus to exercise counter wrap.
module tb_multicycle_main_controller;

  typedef enum int {K_LOAD, K_STORE, K_JUMP, K_BRANCH, K_C, K_D, K_ERR} kind_e;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  Op;
  logic [8:0]  Func;
  logic        isNop, isMoveTo, Zero, MemReady;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg;
  logic        ALUSrcA, ForceAdd, Halted;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [15:0] InstrCount;
  logic [14:0] small_o;
  logic [3:0]  small_cnt;
  logic [14:0] ov;

  int          errors = 0;
  int          checks = 0;
  int unsigned cnt = 0;

  always #5 clk = ~clk;

  multicycle_main_controller #(.COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Func(Func), .isNop(isNop), .isMoveTo(isMoveTo),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ForceAdd(ForceAdd),
    .PCSrc(PCSrc), .Halted(Halted), .InstrCount(InstrCount)
  );

  multicycle_main_controller #(.COUNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Func(Func), .isNop(isNop), .isMoveTo(isMoveTo),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(small_o[14]), .IorD(small_o[13]),
    .MemRead(small_o[12]), .MemWrite(small_o[11]), .IRWrite(small_o[10]),
    .RegWrite(small_o[9]), .RegDst(small_o[8]), .MemToReg(small_o[7]), .ALUSrcA(small_o[6]),
    .ALUSrcB(small_o[5:4]), .ForceAdd(small_o[3]), .PCSrc(small_o[2:1]),
    .Halted(small_o[0]), .InstrCount(small_cnt)
  );

  assign ov = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
               ALUSrcA, ALUSrcB, ForceAdd, PCSrc, Halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input bit pcw, input bit iord, input bit mr, input bit mw,
                                     input bit irw, input bit rw, input bit rd, input bit m2r,
                                     input bit sa, input logic [1:0] sb, input bit fa,
                                     input logic [1:0] ps, input bit h);
    return {pcw, iord, mr, mw, irw, rw, rd, m2r, sa, sb, fa, ps, h};
  endfunction

  function automatic kind_e kind_of(input logic [3:0] op, input logic [8:0] func);
    if (op == 4'd0) return K_LOAD;
    if (op == 4'd1) return K_STORE;
    if (op == 4'd2) return K_JUMP;
    if (op == 4'd4) return K_BRANCH;
    if (op == 4'd8) return (!func[8] && $countones(func) == 1) ? K_C : K_ERR;
    if (op >= 4'd12) return K_D;
    return K_ERR;
  endfunction

  task automatic rnd_side();
    Zero     = 1'($urandom);
    isNop    = 1'($urandom);
    isMoveTo = 1'($urandom);
  endtask

  // One clock: drive MemReady, check outputs and counters, advance to next negedge.
  task automatic cyc(input logic mr, input logic [14:0] exp, input string tag, input bit ret);
    MemReady = mr;
    #1;
    check(tag, 32'(ov), 32'(exp));
    check("count", 32'(InstrCount), 32'(cnt[15:0]));
    check("count4", 32'(small_cnt), 32'(cnt[3:0]));
    @(posedge clk);
    if (ret) cnt++;
    @(negedge clk);
  endtask

  task automatic fetch_decode(input int wf);
    for (int w = 0; w <= wf; w++) begin
      rnd_side();
      if (w == wf) cyc(1'b1, mk(1,0,1,0,1,0,0,0,0,2'd1,1,2'd0,0), "fetch", 1'b0);
      else         cyc(1'b0, mk(0,0,1,0,0,0,0,0,0,2'd0,0,2'd0,0), "fetch_wait", 1'b0);
    end
    rnd_side();
    cyc(1'($urandom), mk(0,0,0,0,0,0,0,0,0,2'd2,1,2'd0,0), "decode", 1'b0);
  endtask

  // Runs a whole instruction; zsel < 0 picks Zero randomly in BRANCH.
  task automatic run_instr(input logic [3:0] op, input logic [8:0] func, input int wf,
                           input int wm, input int zsel);
    kind_e k;
    k = kind_of(op, func);
    Op = op;
    Func = func;
    fetch_decode(wf);
    case (k)
      K_LOAD: begin
        for (int w = 0; w <= wm; w++) begin
          rnd_side();
          cyc(1'(w == wm), mk(0,1,1,0,0,0,0,0,0,2'd0,0,2'd0,0), "ld_mem", 1'b0);
        end
        rnd_side();
        cyc(1'($urandom), mk(0,0,0,0,0,1,0,1,0,2'd0,0,2'd0,0), "ld_wb", 1'b1);
      end
      K_STORE: begin
        for (int w = 0; w <= wm; w++) begin
          rnd_side();
          cyc(1'(w == wm), mk(0,1,0,1,0,0,0,0,0,2'd0,0,2'd0,0), "st_mem", 1'(w == wm));
        end
      end
      K_JUMP: begin
        rnd_side();
        cyc(1'($urandom), mk(1,0,0,0,0,0,0,0,0,2'd0,0,2'd2,0), "jump", 1'b1);
      end
      K_BRANCH: begin
        rnd_side();
        if (zsel >= 0) Zero = 1'(zsel);
        cyc(1'($urandom), mk(Zero,0,0,0,0,0,0,0,1,2'd0,0,2'd1,0), "branch", 1'b1);
      end
      K_C: begin
        rnd_side();
        cyc(1'($urandom), mk(0,0,0,0,0,0,0,0,1,2'd0,0,2'd0,0), "c_exec", 1'b0);
        rnd_side();
        isNop    = (func == 9'h080);
        isMoveTo = (func == 9'h001);
        cyc(1'($urandom), mk(0,0,0,0,0,!isNop,isMoveTo,0,0,2'd0,0,2'd0,0), "c_wb", 1'b1);
      end
      K_D: begin
        rnd_side();
        cyc(1'($urandom), mk(0,0,0,0,0,0,0,0,1,2'd3,0,2'd0,0), "d_exec", 1'b0);
        rnd_side();
        cyc(1'($urandom), mk(0,0,0,0,0,1,0,0,0,2'd0,0,2'd0,0), "d_wb", 1'b1);
      end
      default: begin
        for (int i = 0; i < 20; i++) begin
          rnd_side();
          cyc(1'($urandom), mk(0,0,0,0,0,0,0,0,0,2'd0,0,2'd0,1), "halted", 1'b0);
        end
      end
    endcase
  endtask

  // Assert reset at a negedge, check everything clears, release at the next negedge.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    MemReady = 1'($urandom);
    cnt = 0;
    #1;
    check(tag, 32'(ov), 32'd0);
    check("rst_count", 32'(InstrCount), 32'd0);
    check("rst_count4", 32'(small_cnt), 32'd0);
    @(negedge clk);
    MemReady = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    kind_e k;
    logic [3:0] op;
    logic [8:0] func;
    rst_n = 1'b0;
    Op = 4'd0;
    Func = 9'd0;
    rnd_side();
    MemReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_pulse("reset_outputs");

    run_instr(4'b1100, 9'h155, 0, 0, -1);
    run_instr(4'b0000, 9'h000, 0, 3, -1);
    run_instr(4'b0100, 9'h000, 0, 0, 1);
    run_instr(4'b0100, 9'h000, 0, 0, 0);
    run_instr(4'b1000, 9'h080, 0, 0, -1);
    run_instr(4'b1000, 9'h001, 0, 0, -1);
    run_instr(4'b0001, 9'h000, 2, 1, -1);
    run_instr(4'b0010, 9'h1ff, 1, 0, -1);

    for (int n = 0; n < 150; n++) begin
      k = kind_e'($urandom_range(0, 5));
      func = 9'($urandom);
      case (k)
        K_LOAD:   op = 4'd0;
        K_STORE:  op = 4'd1;
        K_JUMP:   op = 4'd2;
        K_BRANCH: op = 4'd4;
        K_C: begin
          op = 4'd8;
          func = 9'(9'd1 << $urandom_range(0, 7));
        end
        default:  op = 4'($urandom_range(12, 15));
      endcase
      run_instr(op, func, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    end

    // Reset while a store waits for memory.
    Op = 4'd1;
    Func = 9'd0;
    fetch_decode(0);
    rnd_side();
    cyc(1'b0, mk(0,1,0,1,0,0,0,0,0,2'd0,0,2'd0,0), "st_hold", 1'b0);
    MemReady = 1'b0;
    #1;
    check("st_wait_memwrite", 32'(MemWrite), 32'd1);
    reset_pulse("st_abort");
    run_instr(4'b0010, 9'h000, 0, 0, -1);

    run_instr(4'b0011, 9'h000, 0, 0, -1);
    reset_pulse("err_reset");
    run_instr(4'b0010, 9'h000, 0, 0, -1);
    run_instr(4'b1000, 9'h003, 0, 0, -1);
    reset_pulse("err_reset_c");
    run_instr(4'b1000, 9'h100, 0, 0, -1);
    reset_pulse("err_reset_c8");
    run_instr(4'b1101, 9'h000, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
